mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the core_lapido pipeline, directly downstream of the execute stage. It consumes EX/MEM pipeline-register outputs, resolves PC-relative and flag-conditional branches, and performs data-memory loads and stores over a req/ack handshake. It stalls upstream while an access is outstanding and registers the MEM/WB fields for write-back.

## Interface
- GPR_WIDTH, 32, data/address width
- PC_WIDTH, 32, program-counter width
- REG_ADDR_WIDTH, 4, register-file address width
- TIMEOUT, 255, max cycles in REQ before abort (≥1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_mem_write_enable / in_mem_read_enable  in  1 each  store / load request (never both)
- in_is_branch, in_sel_jflag_branch, in_sel_beq_bne, in_sel_jt_jf  in  1 each  branch controls
- in_cond_sel  in  3  flag index for jt/jf
- in_flags  in  6  EX flags; bit0 = zero
- in_wb_res_mux  in  2 ; in_reg_write_enable  in  1 ; in_reg_dest  in  REG_ADDR_WIDTH
- in_alu_res, in_mem_addr, in_mem_data, in_imm  in  GPR_WIDTH
- in_next_pc, in_branch_addr  in  PC_WIDTH
- dmem_req, dmem_we  out  1 ; dmem_addr, dmem_wdata  out  GPR_WIDTH
- dmem_rdata  in  GPR_WIDTH ; dmem_ack  in  1
- stall  out  1  hold all upstream stage registers
- out_branch_taken  out  1 ; out_branch_addr  out  PC_WIDTH
- out_mem_fault  out  1  one-cycle pulse on timeout
- out_wb_res_mux  out  2 ; out_reg_write_enable  out  1 ; out_reg_dest  out  REG_ADDR_WIDTH
- out_alu_res, out_load_data, out_imm  out  GPR_WIDTH ; out_next_pc  out  PC_WIDTH

## Operation
- FSM states: IDLE, REQ.
- IDLE, no access (both enables 0): register all in_* WB fields to out_* at edge; resolve branch.
- Branch resolution (IDLE, in_is_branch=1):
  - sel_jflag_branch=0: taken = flags[0] XOR sel_beq_bne (0=beq, 1=bne).
  - sel_jflag_branch=1: taken = flags[cond_sel] XOR sel_jt_jf (0=jt, 1=jf); cond_sel 6/7 → not taken.
  - out_branch_taken registered; out_branch_addr = in_branch_addr registered. Pulse is exactly 1 cycle.
- IDLE, access: latch addr, wdata, we, WB fields; go REQ; out_reg_write_enable <= 0 (bubble).
- REQ: dmem_req=1, dmem_addr/wdata/we from latches, stable until ack or timeout. stall=1. Timeout counter increments each REQ cycle.
- REQ with dmem_ack=1: out_load_data <= dmem_rdata (loads; stores keep previous value), latched WB fields to out_*, counter cleared, go IDLE.
- REQ, counter reaches TIMEOUT without ack: drop dmem_req, go IDLE, out_mem_fault pulse, out_reg_write_enable <= 0 (write-back suppressed).
- stall = (state==REQ), combinational. Inputs ignored while stall=1; upstream holds them.
- Branch with memory enables asserted is illegal; branch fields ignored if access set.

## Timing
- Reset (async): state IDLE, counter 0, dmem_req/dmem_we 0, dmem_addr/wdata 0, stall 0, all out_* 0.
- Reset mid-REQ: dmem_req deasserts immediately (combinational with rst), no fault pulse.
- Non-memory op: 1-cycle latency, no stall.
- Access accepted in cycle 0: dmem_req high from cycle 1; ack in cycle k (k≥1) → out_* valid in cycle k+1; stall high cycles 1..k; next instruction processed in cycle k+1.
- dmem_ack outside REQ ignored. Ack in the same cycle the counter reaches TIMEOUT: ack wins, no fault.
- Back-to-back accesses: cycle k+1 IDLE accepts the held op, dmem_req low for exactly one cycle between transactions.

## Test plan
- ALU op: alu_res=0x0000_002A, rd=3, rwe=1 → next cycle out_alu_res=0x2A, out_reg_dest=3, out_reg_write_enable=1, stall never high.
- beq, flags=6'b000001, branch_addr=0x40 → out_branch_taken=1 for one cycle, out_branch_addr=0x40; same with bne → taken=0.
- jf, cond_sel=2, flags[2]=0 → taken=1; cond_sel=7 → taken=0.
- Load addr 0x100, ack after 3 REQ cycles with rdata=0xDEADBEEF → stall high 3 cycles, dmem_addr=0x100 throughout, out_load_data=0xDEADBEEF with rwe=1 next cycle.
- Store addr 0x8, data 0x55, ack on first REQ cycle → dmem_we=1, wdata=0x55, stall 1 cycle; immediate next load issues after one idle cycle.
- No ack, TIMEOUT=4 → dmem_req drops after 4 REQ cycles, out_mem_fault pulses once, out_reg_write_enable=0; assert rst mid-REQ in a second run → dmem_req and stall drop within the same cycle.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage; branch resolution, req/ack data-memory access
// with timeout abort, upstream stall and registered MEM/WB outputs.
module mem_stage #(
   parameter int GPR_WIDTH      = 32,
   parameter int PC_WIDTH       = 32,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int TIMEOUT        = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_mem_write_enable,
   input  logic                      in_mem_read_enable,
   input  logic                      in_is_branch,
   input  logic                      in_sel_jflag_branch,
   input  logic                      in_sel_beq_bne,
   input  logic                      in_sel_jt_jf,
   input  logic [2:0]                in_cond_sel,
   input  logic [5:0]                in_flags,
   input  logic [1:0]                in_wb_res_mux,
   input  logic                      in_reg_write_enable,
   input  logic [REG_ADDR_WIDTH-1:0] in_reg_dest,
   input  logic [GPR_WIDTH-1:0]      in_alu_res,
   input  logic [GPR_WIDTH-1:0]      in_mem_addr,
   input  logic [GPR_WIDTH-1:0]      in_mem_data,
   input  logic [GPR_WIDTH-1:0]      in_imm,
   input  logic [PC_WIDTH-1:0]       in_next_pc,
   input  logic [PC_WIDTH-1:0]       in_branch_addr,
   output logic                      dmem_req,
   output logic                      dmem_we,
   output logic [GPR_WIDTH-1:0]      dmem_addr,
   output logic [GPR_WIDTH-1:0]      dmem_wdata,
   input  logic [GPR_WIDTH-1:0]      dmem_rdata,
   input  logic                      dmem_ack,
   output logic                      stall,
   output logic                      out_branch_taken,
   output logic [PC_WIDTH-1:0]       out_branch_addr,
   output logic                      out_mem_fault,
   output logic [1:0]                out_wb_res_mux,
   output logic                      out_reg_write_enable,
   output logic [REG_ADDR_WIDTH-1:0] out_reg_dest,
   output logic [GPR_WIDTH-1:0]      out_alu_res,
   output logic [GPR_WIDTH-1:0]      out_load_data,
   output logic [GPR_WIDTH-1:0]      out_imm,
   output logic [PC_WIDTH-1:0]       out_next_pc
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [0:0] IDLE = 1'b0, REQ = 1'b1;

   logic [0:0]                state;
   logic [CW-1:0]             cnt;
   logic                      we_q, l_rwe;
   logic [1:0]                l_wb;
   logic [REG_ADDR_WIDTH-1:0] l_rd;
   logic [GPR_WIDTH-1:0]      l_alu, l_imm;
   logic [PC_WIDTH-1:0]       l_pc;
   logic [7:0]                fl;
   logic                      access, taken;

   // flags padded to 8 so cond_sel 6/7 index a zero and resolve as not taken
   always_comb begin
      fl     = {2'b00, in_flags};
      access = in_mem_write_enable | in_mem_read_enable;
      taken  = in_is_branch & (in_sel_jflag_branch ? (in_cond_sel < 3'd6) & (fl[in_cond_sel] ^ in_sel_jt_jf)
                                                    : in_flags[0] ^ in_sel_beq_bne);
   end

   assign stall    = (state == REQ) & ~rst;
   assign dmem_req = stall;
   assign dmem_we  = stall & we_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state                <= IDLE;
         cnt                  <= '0;
         we_q                 <= 1'b0;
         dmem_addr            <= '0;
         dmem_wdata           <= '0;
         l_rwe                <= 1'b0;
         l_wb                 <= '0;
         l_rd                 <= '0;
         l_alu                <= '0;
         l_imm                <= '0;
         l_pc                 <= '0;
         out_branch_taken     <= 1'b0;
         out_branch_addr      <= '0;
         out_mem_fault        <= 1'b0;
         out_wb_res_mux       <= '0;
         out_reg_write_enable <= 1'b0;
         out_reg_dest         <= '0;
         out_alu_res          <= '0;
         out_load_data        <= '0;
         out_imm              <= '0;
         out_next_pc          <= '0;
      end else begin
         out_mem_fault    <= 1'b0;
         out_branch_taken <= 1'b0;
         if (state == IDLE) begin
            if (access) begin
               state                <= REQ;
               cnt                  <= '0;
               we_q                 <= in_mem_write_enable;
               dmem_addr            <= in_mem_addr;
               dmem_wdata           <= in_mem_data;
               l_rwe                <= in_reg_write_enable;
               l_wb                 <= in_wb_res_mux;
               l_rd                 <= in_reg_dest;
               l_alu                <= in_alu_res;
               l_imm                <= in_imm;
               l_pc                 <= in_next_pc;
               out_reg_write_enable <= 1'b0;
            end else begin
               out_branch_taken     <= taken;
               out_branch_addr      <= in_branch_addr;
               out_wb_res_mux       <= in_wb_res_mux;
               out_reg_write_enable <= in_reg_write_enable;
               out_reg_dest         <= in_reg_dest;
               out_alu_res          <= in_alu_res;
               out_imm              <= in_imm;
               out_next_pc          <= in_next_pc;
            end
         end else if (dmem_ack) begin
            state                <= IDLE;
            cnt                  <= '0;
            out_load_data        <= we_q ? out_load_data : dmem_rdata;
            out_wb_res_mux       <= l_wb;
            out_reg_write_enable <= l_rwe;
            out_reg_dest         <= l_rd;
            out_alu_res          <= l_alu;
            out_imm              <= l_imm;
            out_next_pc          <= l_pc;
         end else if (cnt == CW'(TIMEOUT - 1)) begin
            state                <= IDLE;
            cnt                  <= '0;
            out_mem_fault        <= 1'b1;
            out_reg_write_enable <= 1'b0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage (TIMEOUT=4).
module tb_mem_stage;
   logic        clk, rst;
   logic        mwe, mre, isb, jfl, bne, jf;
   logic [2:0]  csel;
   logic [5:0]  flags;
   logic [1:0]  wbm;
   logic        rwe;
   logic [3:0]  rd;
   logic [31:0] alu, maddr, mdata, imm, npc, baddr;
   logic        dreq, dwe, dack;
   logic [31:0] daddr, dwdata, drdata;
   logic        stall, btaken, fault;
   logic [31:0] obaddr;
   logic [1:0]  owbm;
   logic        orwe;
   logic [3:0]  ord;
   logic [31:0] oalu, oload, oimm, onpc;
   int          tests, fails;

   mem_stage #(.GPR_WIDTH(32), .PC_WIDTH(32), .REG_ADDR_WIDTH(4), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .in_mem_write_enable(mwe), .in_mem_read_enable(mre),
      .in_is_branch(isb), .in_sel_jflag_branch(jfl), .in_sel_beq_bne(bne), .in_sel_jt_jf(jf),
      .in_cond_sel(csel), .in_flags(flags), .in_wb_res_mux(wbm), .in_reg_write_enable(rwe),
      .in_reg_dest(rd), .in_alu_res(alu), .in_mem_addr(maddr), .in_mem_data(mdata), .in_imm(imm),
      .in_next_pc(npc), .in_branch_addr(baddr),
      .dmem_req(dreq), .dmem_we(dwe), .dmem_addr(daddr), .dmem_wdata(dwdata),
      .dmem_rdata(drdata), .dmem_ack(dack), .stall(stall),
      .out_branch_taken(btaken), .out_branch_addr(obaddr), .out_mem_fault(fault),
      .out_wb_res_mux(owbm), .out_reg_write_enable(orwe), .out_reg_dest(ord),
      .out_alu_res(oalu), .out_load_data(oload), .out_imm(oimm), .out_next_pc(onpc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic nop();
      mwe = 0; mre = 0; isb = 0; jfl = 0; bne = 0; jf = 0; csel = 0; flags = 0;
      wbm = 0; rwe = 0; rd = 0; alu = 0; maddr = 0; mdata = 0; imm = 0; npc = 0; baddr = 0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; dack = 0; drdata = 0; nop();
      repeat (2) @(posedge clk);
      #1;
      tests++; if (dreq !== 1'b0 || stall !== 1'b0 || dwe !== 1'b0) begin $display("FAIL reset_req: req=%b stall=%b we=%b want 0", dreq, stall, dwe); fails++; end
      tests++; if (daddr !== 0 || dwdata !== 0) begin $display("FAIL reset_bus: addr=%h wdata=%h want 0", daddr, dwdata); fails++; end
      tests++; if ({btaken, fault, orwe, owbm, ord} !== 0 || {obaddr, oalu, oload, oimm, onpc} !== 0) begin $display("FAIL reset_out: outputs not all zero"); fails++; end
      @(negedge clk) rst = 0;
   endtask

   task automatic test_alu();
      step(); nop(); alu = 32'h2A; rd = 3; rwe = 1; wbm = 2'd2; imm = 32'h77; npc = 32'h1004;
      dack = 1; drdata = 32'hFFFF_FFFF;
      tests++; if (stall !== 1'b0) begin $display("FAIL alu_stall_pre: stall=%b want 0", stall); fails++; end
      step(); nop(); dack = 0;
      tests++; if (oalu !== 32'h2A || ord !== 4'd3 || orwe !== 1'b1) begin $display("FAIL alu_out: alu=%h rd=%0d rwe=%b want 2a 3 1", oalu, ord, orwe); fails++; end
      tests++; if (owbm !== 2'd2 || oimm !== 32'h77 || onpc !== 32'h1004) begin $display("FAIL alu_wb: wbm=%0d imm=%h npc=%h want 2 77 1004", owbm, oimm, onpc); fails++; end
      tests++; if (stall !== 1'b0 || dreq !== 1'b0) begin $display("FAIL alu_stall: stall=%b req=%b want 0 0", stall, dreq); fails++; end
      tests++; if (oload !== 32'h0) begin $display("FAIL ack_idle_ignored: load=%h want 0", oload); fails++; end
   endtask

   task automatic test_branch();
      isb = 1; flags = 6'b000001; baddr = 32'h40;
      step(); nop();
      tests++; if (btaken !== 1'b1 || obaddr !== 32'h40) begin $display("FAIL beq_taken: taken=%b addr=%h want 1 40", btaken, obaddr); fails++; end
      step();
      tests++; if (btaken !== 1'b0) begin $display("FAIL beq_pulse: taken=%b want 0", btaken); fails++; end
      isb = 1; bne = 1; flags = 6'b000001; baddr = 32'h40;
      step(); nop();
      tests++; if (btaken !== 1'b0) begin $display("FAIL bne_not_taken: taken=%b want 0", btaken); fails++; end
      isb = 1; jfl = 1; jf = 1; csel = 3'd2; flags = 6'b111011; baddr = 32'h80;
      step(); nop();
      tests++; if (btaken !== 1'b1 || obaddr !== 32'h80) begin $display("FAIL jf_taken: taken=%b addr=%h want 1 80", btaken, obaddr); fails++; end
      isb = 1; jfl = 1; jf = 1; csel = 3'd7; flags = 6'b000000;
      step(); nop();
      tests++; if (btaken !== 1'b0) begin $display("FAIL jf_cond7: taken=%b want 0", btaken); fails++; end
      isb = 1; jfl = 1; jf = 0; csel = 3'd4; flags = 6'b010000;
      step(); nop();
      tests++; if (btaken !== 1'b1) begin $display("FAIL jt_taken: taken=%b want 1", btaken); fails++; end
   endtask

   task automatic test_load();
      int sc;
      sc = 0;
      mre = 1; maddr = 32'h100; rd = 5; rwe = 1; wbm = 2'd1;
      for (int c = 1; c <= 3; c++) begin
         step();
         if (stall) sc++;
         tests++; if (dreq !== 1'b1 || daddr !== 32'h100 || dwe !== 1'b0) begin $display("FAIL load_req_c%0d: req=%b addr=%h we=%b want 1 100 0", c, dreq, daddr, dwe); fails++; end
         tests++; if (orwe !== 1'b0) begin $display("FAIL load_bubble_c%0d: rwe=%b want 0", c, orwe); fails++; end
         if (c == 3) begin dack = 1; drdata = 32'hDEADBEEF; end
      end
      step(); nop(); dack = 0; drdata = 0;
      if (stall) sc++;
      tests++; if (sc !== 3) begin $display("FAIL load_stall_cycles: got %0d want 3", sc); fails++; end
      tests++; if (oload !== 32'hDEADBEEF || orwe !== 1'b1 || ord !== 4'd5 || owbm !== 2'd1) begin $display("FAIL load_out: data=%h rwe=%b rd=%0d wbm=%0d want deadbeef 1 5 1", oload, orwe, ord, owbm); fails++; end
      tests++; if (dreq !== 1'b0) begin $display("FAIL load_req_drop: req=%b want 0", dreq); fails++; end
      step();
      tests++; if (orwe !== 1'b0 || oload !== 32'hDEADBEEF) begin $display("FAIL load_after: rwe=%b data=%h want 0 deadbeef", orwe, oload); fails++; end
   endtask

   task automatic test_back_to_back();
      mwe = 1; maddr = 32'h8; mdata = 32'h55;
      step();
      tests++; if (dreq !== 1'b1 || dwe !== 1'b1 || dwdata !== 32'h55 || daddr !== 32'h8 || stall !== 1'b1) begin $display("FAIL store_req: req=%b we=%b wdata=%h addr=%h stall=%b", dreq, dwe, dwdata, daddr, stall); fails++; end
      dack = 1; drdata = 32'h99999999;
      step(); nop(); dack = 0; mre = 1; maddr = 32'h200; rd = 7; rwe = 1;
      tests++; if (dreq !== 1'b0 || stall !== 1'b0) begin $display("FAIL b2b_gap: req=%b stall=%b want 0 0", dreq, stall); fails++; end
      tests++; if (oload !== 32'hDEADBEEF) begin $display("FAIL store_keeps_load: data=%h want deadbeef", oload); fails++; end
      step();
      tests++; if (dreq !== 1'b1 || daddr !== 32'h200 || dwe !== 1'b0) begin $display("FAIL b2b_load_req: req=%b addr=%h we=%b want 1 200 0", dreq, daddr, dwe); fails++; end
      dack = 1; drdata = 32'h12345678;
      step(); nop(); dack = 0;
      tests++; if (oload !== 32'h12345678 || orwe !== 1'b1 || ord !== 4'd7) begin $display("FAIL b2b_load_out: data=%h rwe=%b rd=%0d want 12345678 1 7", oload, orwe, ord); fails++; end
   endtask

   task automatic test_timeout();
      int fc;
      fc = 0;
      mre = 1; maddr = 32'h300; rd = 9; rwe = 1;
      for (int c = 1; c <= 4; c++) begin
         step();
         if (fault) fc++;
         tests++; if (dreq !== 1'b1) begin $display("FAIL timeout_req_c%0d: req=%b want 1", c, dreq); fails++; end
      end
      step(); nop();
      if (fault) fc++;
      tests++; if (dreq !== 1'b0 || stall !== 1'b0) begin $display("FAIL timeout_drop: req=%b stall=%b want 0 0", dreq, stall); fails++; end
      tests++; if (fault !== 1'b1 || orwe !== 1'b0) begin $display("FAIL timeout_fault: fault=%b rwe=%b want 1 0", fault, orwe); fails++; end
      tests++; if (oload !== 32'h12345678) begin $display("FAIL timeout_load_kept: data=%h want 12345678", oload); fails++; end
      step();
      if (fault) fc++;
      tests++; if (fc !== 1) begin $display("FAIL timeout_pulses: got %0d want 1", fc); fails++; end
   endtask

   task automatic test_ack_at_timeout();
      mre = 1; maddr = 32'h304; rd = 4; rwe = 1;
      repeat (3) step();
      step();
      dack = 1; drdata = 32'hCAFEF00D;
      step(); nop(); dack = 0;
      tests++; if (fault !== 1'b0 || oload !== 32'hCAFEF00D || orwe !== 1'b1 || ord !== 4'd4) begin $display("FAIL ack_wins: fault=%b data=%h rwe=%b rd=%0d want 0 cafef00d 1 4", fault, oload, orwe, ord); fails++; end
   endtask

   task automatic test_reset_mid_req();
      mre = 1; maddr = 32'h400; rwe = 1;
      step(); step();
      tests++; if (dreq !== 1'b1 || stall !== 1'b1) begin $display("FAIL midrst_pre: req=%b stall=%b want 1 1", dreq, stall); fails++; end
      #2 rst = 1;
      #1;
      tests++; if (dreq !== 1'b0 || stall !== 1'b0) begin $display("FAIL midrst_drop: req=%b stall=%b want 0 0", dreq, stall); fails++; end
      @(negedge clk) begin rst = 0; nop(); end
      step();
      tests++; if (fault !== 1'b0 || dreq !== 1'b0 || oload !== 32'h0) begin $display("FAIL midrst_after: fault=%b req=%b data=%h want 0 0 0", fault, dreq, oload); fails++; end
   endtask

   initial begin
      tests = 0; fails = 0;
      test_reset();
      test_alu();
      test_branch();
      test_load();
      test_back_to_back();
      test_timeout();
      test_ack_at_timeout();
      test_reset_mid_req();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
